// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the buffered writeback request type and the x0 constant
// used by the register-file writeback arbiter.
package regfile_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;

  localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  function automatic logic is_reg_zero(input logic [ADDRESS_WIDTH-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ valid/ready lanes with flattened address/data slices.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH
);

  logic [NUM_REQ-1:0]               wb_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] wb_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]    wb_data;
  logic [NUM_REQ-1:0]               wb_ready;

  modport master (
    output wb_valid,
    output wb_addr,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_addr,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Request vector to one-hot grant: round-robin from ptr_i by default,
// lowest-index-wins when WB_ARB_FIXED_PRIO_EN is defined (no pointer port then).
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef WB_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  // Scan requesters in priority order and latch onto the first one found
  always_comb begin
    int  idx;
    logic hit;
    idx       = 0;
    hit       = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      idx = off;
`else
      idx = (int'(ptr_i) + off) % NUM_REQ;
`endif
      hit        = !gnt_vld_o && req_i[idx];
      gnt_o[idx] = gnt_o[idx] | hit;
      gnt_idx_o  = hit ? IDX_W'(idx) : gnt_idx_o;
      gnt_vld_o  = gnt_vld_o | hit;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NUM_REQ writeback sources via 1-entry
// holding buffers and a registered write command. Define WB_ARB_FIXED_PRIO_EN for fixed priority.
module regfile_wb_arbiter #(
  parameter  int NUM_REQ       = 2,
  parameter  int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter  int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_arbiter_if.slave      wb,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic                     WE3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     idle
);

  import regfile_pkg::REG_ZERO;

  logic [NUM_REQ-1:0]                    hold_vld_q, hold_vld_d;
  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
  logic                                  we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0]              ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]                 wd3_q, wd3_d;

  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic               gnt_vld_s;
  logic [NUM_REQ-1:0] accept_s;

`ifndef WB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (hold_vld_q),
`ifndef WB_ARB_FIXED_PRIO_EN
    .ptr_i     (rr_ptr_q),
`endif
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // A buffer being drained this cycle can be refilled on the same edge
  assign wb.wb_ready = ~hold_vld_q | gnt_s;
  assign accept_s    = wb.wb_valid & wb.wb_ready;

  // Buffer capture/retire and write-command next state
  always_comb begin
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_vld_d  = (hold_vld_q & ~gnt_s) | accept_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_s[i]) begin
        hold_addr_d[i] = wb.wb_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        hold_data_d[i] = wb.wb_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        hold_addr_d[i] = hold_addr_q[i];
        hold_data_d[i] = hold_data_q[i];
      end
    end
    if (gnt_vld_s) begin
      // x0 retires like any other write but never raises the enable
      we3_d = hold_addr_q[gnt_idx_s] != ADDRESS_WIDTH'(REG_ZERO);
      ad3_d = hold_addr_q[gnt_idx_s];
      wd3_d = hold_data_q[gnt_idx_s];
    end else begin
      we3_d = 1'b0;
      ad3_d = ad3_q;
      wd3_d = wd3_q;
    end
  end

`ifndef WB_ARB_FIXED_PRIO_EN
  // Pointer moves just past the granted requester; holds when nothing is granted
  always_comb begin
    if (!gnt_vld_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = gnt_idx_s + IDX_W'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Buffer and write-port registers; reset discards buffered and in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      we3_q       <= 1'b0;
      ad3_q       <= '0;
      wd3_q       <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      we3_q       <= we3_d;
      ad3_q       <= ad3_d;
      wd3_q       <= wd3_d;
    end
  end

  assign AD3  = ad3_q;
  assign WE3  = we3_q;
  assign WD3  = wd3_q;
  assign idle = !(|hold_vld_q) && !we3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a transaction-level model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) wb ();

  logic [ADDRESS_WIDTH-1:0] AD3;
  logic                     WE3;
  logic [DATA_WIDTH-1:0]    WD3;
  logic                     idle;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .wb   (wb),
    .AD3  (AD3),
    .WE3  (WE3),
    .WD3  (WD3),
    .idle (idle)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: per-requester pending write, turn pointer, write issued this cycle, register file
  wb_req_t         m_hold [N];
  bit              m_vld  [N];
  int              m_ptr;
  bit              m_we;
  wb_req_t         m_out;
  logic [DATA_WIDTH-1:0] m_rf   [32];
  logic [DATA_WIDTH-1:0] dut_rf [32];

  bit      in_v [N];
  wb_req_t in_r [N];

  // Register file as seen by the write port
  always @(posedge clk) if (WE3 === 1'b1) dut_rf[AD3] <= WD3;

  function automatic int m_grant();
    int idx;
    for (int off = 0; off < N; off++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      idx = off;
`else
      idx = (m_ptr + off) % N;
`endif
      if (m_vld[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_vld[i]  = 1'b0;
      m_hold[i] = '0;
    end
    m_ptr = 0;
    m_we  = 1'b0;
    m_out = '0;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      wb.wb_valid[i] = in_v[i];
      wb.wb_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = in_r[i].addr;
      wb.wb_data[i*DATA_WIDTH +: DATA_WIDTH]       = in_r[i].data;
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      in_v[i] = 1'b0;
      in_r[i] = '0;
    end
  endtask

  // One clock: compare DUT against model mid-cycle, then advance the model at the edge
  task automatic tick();
    int g;
    logic [N-1:0] exp_rdy;
    logic exp_idle;
    apply();
    @(negedge clk);
    g = m_grant();
    exp_idle = !m_we;
    for (int i = 0; i < N; i++) begin
      exp_rdy[i] = !m_vld[i] || (g == i);
      if (m_vld[i]) exp_idle = 1'b0;
    end
    vectors++;
    if (wb.wb_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL wb_ready @%0t: got %b expected %b", $time, wb.wb_ready, exp_rdy);
    end
    vectors++;
    if (WE3 !== m_we) begin
      miscompares++;
      $display("FAIL WE3 @%0t: got %b expected %b", $time, WE3, m_we);
    end
    vectors++;
    if (AD3 !== m_out.addr || WD3 !== m_out.data) begin
      miscompares++;
      $display("FAIL AD3/WD3 @%0t: got %0d/%h expected %0d/%h", $time, AD3, WD3, m_out.addr, m_out.data);
    end
    vectors++;
    if (idle !== exp_idle) begin
      miscompares++;
      $display("FAIL idle @%0t: got %b expected %b", $time, idle, exp_idle);
    end
    @(posedge clk);
    if (m_we) m_rf[m_out.addr] = m_out.data;
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_we     = (m_hold[g].addr != REG_ZERO);
        m_out    = m_hold[g];
        m_ptr    = (g + 1) % N;
        m_vld[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (in_v[i] && exp_rdy[i]) begin
          m_hold[i] = in_r[i];
          m_vld[i]  = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    apply();
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    vectors++;
    if (WE3 !== 1'b0 || AD3 !== 5'd0 || WD3 !== 32'd0 || idle !== 1'b1 || wb.wb_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_state: got we=%b ad=%0d wd=%h idle=%b rdy=%b expected 0/0/0/1/11",
               WE3, AD3, WD3, idle, wb.wb_ready);
    end
    tick();
  endtask

  task automatic test_single_write();
    in_v[0] = 1'b1;
    in_r[0] = '{addr: 5'd5, data: 32'hDEAD_BEEF};
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (WE3 !== 1'b1 || AD3 !== 5'd5 || WD3 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_latency: got we=%b ad=%0d wd=%h expected 1/5/deadbeef", WE3, AD3, WD3);
    end
    repeat (2) tick();
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle: got %b expected 1", idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDRESS_WIDTH-1:0] prev_ad;
    prev_ad = '0;
    for (int c = 0; c < 10; c++) begin
      in_v[0] = 1'b1;
      in_v[1] = 1'b1;
      in_r[0] = '{addr: 5'd1, data: $urandom};
      in_r[1] = '{addr: 5'd2, data: $urandom};
      tick();
      if (c >= 1) begin
        vectors++;
        if (WE3 !== 1'b1 || (c >= 2 && AD3 === prev_ad)) begin
          miscompares++;
          $display("FAIL b2b_alternate cycle %0d: got we=%b ad=%0d expected we=1 ad!=%0d", c, WE3, AD3, prev_ad);
        end
      end
      prev_ad = AD3;
    end
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_x0_write();
    int we_seen;
    we_seen = 0;
    in_v[0] = 1'b1;
    in_r[0] = '{addr: 5'd0, data: 32'h0000_1234};
    tick();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (WE3 === 1'b1) we_seen++;
    end
    vectors++;
    if (we_seen !== 0 || wb.wb_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL x0_write: got we_count=%0d rdy=%b expected 0/11", we_seen, wb.wb_ready);
    end
  endtask

  task automatic test_same_addr();
    in_v[0] = 1'b1;
    in_r[0] = '{addr: 5'd3, data: 32'h0000_0003};
    tick();
    clear_inputs();
    tick();
    in_v[0] = 1'b1;
    in_v[1] = 1'b1;
    in_r[0] = '{addr: 5'd7, data: 32'h0000_000A};
    in_r[1] = '{addr: 5'd7, data: 32'h0000_000B};
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (WE3 !== 1'b1 || AD3 !== 5'd7 || WD3 !== 32'h0000_000B) begin
      miscompares++;
      $display("FAIL same_addr_first: got we=%b ad=%0d wd=%h expected 1/7/b", WE3, AD3, WD3);
    end
    tick();
    vectors++;
    if (WE3 !== 1'b1 || AD3 !== 5'd7 || WD3 !== 32'h0000_000A) begin
      miscompares++;
      $display("FAIL same_addr_second: got we=%b ad=%0d wd=%h expected 1/7/a", WE3, AD3, WD3);
    end
    repeat (3) tick();
    vectors++;
    if (dut_rf[7] !== 32'h0000_000A) begin
      miscompares++;
      $display("FAIL same_addr_final: got reg7=%h expected a", dut_rf[7]);
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 3; c++) begin
      in_v[0] = 1'b1;
      in_v[1] = 1'b1;
      in_r[0] = '{addr: 5'($urandom_range(1, 31)), data: $urandom};
      in_r[1] = '{addr: 5'($urandom_range(1, 31)), data: $urandom};
      tick();
    end
    vectors++;
    if (WE3 !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_busy: got we=%b expected 1", WE3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    vectors++;
    if (WE3 !== 1'b0 || idle !== 1'b1 || wb.wb_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL midflight_reset: got we=%b idle=%b rdy=%b expected 0/1/11", WE3, idle, wb.wb_ready);
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        in_v[i] = ($urandom_range(0, 3) != 0);
        in_r[i] = '{addr: 5'($urandom_range(0, 7)), data: $urandom};
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    repeat (4) tick();
    for (int r = 1; r < 32; r++) begin
      vectors++;
      if (dut_rf[r] !== m_rf[r]) begin
        miscompares++;
        $display("FAIL random_regfile x%0d: got %h expected %h", r, dut_rf[r], m_rf[r]);
      end
    end
  endtask

`ifdef WB_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int c = 0; c < 8; c++) begin
      in_v[0] = 1'b1;
      in_v[1] = 1'b1;
      in_r[0] = '{addr: 5'd4, data: $urandom};
      in_r[1] = '{addr: 5'd6, data: $urandom};
      tick();
      if (c >= 1) begin
        vectors++;
        if (wb.wb_ready[1] !== 1'b0 || (c >= 2 && AD3 !== 5'd4)) begin
          miscompares++;
          $display("FAIL fixed_prio cycle %0d: got rdy1=%b ad=%0d expected 0/4", c, wb.wb_ready[1], AD3);
        end
      end
    end
    in_v[0] = 1'b0;
    repeat (4) tick();
    clear_inputs();
    repeat (3) tick();
  endtask
`endif

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      dut_rf[r] = '0;
    end
    clear_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_x0_write();
    test_same_addr();
    test_reset_midflight();
`ifdef WB_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
